// File: rtl/sdr_port_arbiter.sv
// Round-robin arbiter sharing one SDR controller among NUM_PORTS clients.
// One grant at a time; the grant is held until BURST_LEN beats finish or the watchdog fires.
module sdr_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_PORTS-1:0]        port_req_i,
  input  logic [NUM_PORTS-1:0]        port_we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wdata_i,
  input  logic [NUM_PORTS-1:0]        port_wr_vld_i,
  output logic [NUM_PORTS-1:0]        port_wr_ready_o,
  output logic [DATA_W-1:0]           port_rdata_o,
  output logic [NUM_PORTS-1:0]        port_rd_vld_o,
  output logic [NUM_PORTS-1:0]        port_grant_o,
  output logic [NUM_PORTS-1:0]        port_done_o,
  output logic [NUM_PORTS-1:0]        port_err_o,
  output logic                        sdr_wr_req_o,
  output logic                        sdr_rd_req_o,
  output logic [ADDR_W-1:0]           sdr_waddr_o,
  output logic [ADDR_W-1:0]           sdr_raddr_o,
  output logic [DATA_W-1:0]           sdr_wdata_in_o,
  output logic                        sdr_wr_vld_o,
  input  logic                        sdr_wr_ready_i,
  input  logic [DATA_W-1:0]           sdr_rdata_out_i,
  input  logic                        sdr_rd_vld_i
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, XFER = 2'd2, DONE = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         rr_q, rr_d, g_q, g_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [NUM_PORTS-1:0]  grant_q, grant_d, done_q, done_d, err_q, err_d;
  logic                  wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic [BW-1:0]         beat_q, beat_d, beat_nxt_s;
  logic [TW-1:0]         tmo_q, tmo_d, tmo_nxt_s;

  logic                  found_s, we_sel_s, wr_vld_sel_s, xfer_s, beat_s;
  logic [PW-1:0]         win_s;
  int                    pos_s;
  logic [ADDR_W-1:0]     addr_sel_s;
  logic [DATA_W-1:0]     wdata_sel_s;
  logic [NUM_PORTS-1:0]  onehot_s;

  // First requester at or above the rr pointer, wrapping around.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    pos_s   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      pos_s = int'(rr_q) + k;
      if (pos_s >= NUM_PORTS) begin
        pos_s = pos_s - NUM_PORTS;
      end else begin
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found_s && port_req_i[i] && (pos_s == i)) begin
          found_s = 1'b1;
          win_s   = PW'(i);
        end else begin
        end
      end
    end
  end

  always_comb begin
    we_sel_s     = 1'b0;
    addr_sel_s   = '0;
    onehot_s     = '0;
    wdata_sel_s  = '0;
    wr_vld_sel_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (PW'(i) == win_s) begin
        we_sel_s    = port_we_i[i];
        addr_sel_s  = port_addr_i[i*ADDR_W +: ADDR_W];
        onehot_s[i] = 1'b1;
      end else begin
      end
      if (grant_q[i]) begin
        wdata_sel_s  = port_wdata_i[i*DATA_W +: DATA_W];
        wr_vld_sel_s = port_wr_vld_i[i];
      end else begin
      end
    end
  end

  assign xfer_s     = (state_q == XFER);
  assign beat_s     = xfer_s & (we_q ? (wr_vld_sel_s & sdr_wr_ready_i) : sdr_rd_vld_i);
  assign beat_nxt_s = beat_q + BW'(beat_s);
  assign tmo_nxt_s  = tmo_q + TW'(1);

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    g_d      = g_q;
    we_d     = we_q;
    addr_d   = addr_q;
    grant_d  = grant_q;
    done_d   = '0;
    err_d    = '0;
    wr_req_d = 1'b0;
    rd_req_d = 1'b0;
    beat_d   = beat_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d  = ISSUE;
          g_d      = win_s;
          we_d     = we_sel_s;
          addr_d   = addr_sel_s;
          grant_d  = onehot_s;
          wr_req_d = we_sel_s;
          rd_req_d = ~we_sel_s;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        beat_d  = '0;
        tmo_d   = '0;
        state_d = XFER;
      end
      XFER: begin
        beat_d = beat_nxt_s;
        tmo_d  = tmo_nxt_s;
        if (beat_nxt_s == BW'(BURST_LEN)) begin
          state_d = DONE;
          done_d  = grant_q;
        end else if (tmo_nxt_s == TW'(TIMEOUT)) begin
          // A beat landing on the expiry cycle still counts as progress.
          state_d = DONE;
          done_d  = grant_q;
          err_d   = beat_s ? '0 : grant_q;
        end else begin
          state_d = XFER;
        end
      end
      DONE: begin
        grant_d = '0;
        rr_d    = (g_q == PW'(NUM_PORTS - 1)) ? '0 : g_q + PW'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      g_q      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      beat_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      g_q      <= g_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
    end
  end

  assign port_grant_o    = grant_q;
  assign port_done_o     = done_q;
  assign port_err_o      = err_q;
  assign sdr_wr_req_o    = wr_req_q;
  assign sdr_rd_req_o    = rd_req_q;
  assign sdr_waddr_o     = addr_q;
  assign sdr_raddr_o     = addr_q;
  assign sdr_wdata_in_o  = wdata_sel_s;
  assign sdr_wr_vld_o    = wr_vld_sel_s & xfer_s & we_q;
  assign port_wr_ready_o = grant_q & {NUM_PORTS{sdr_wr_ready_i & xfer_s & we_q}};
  assign port_rd_vld_o   = grant_q & {NUM_PORTS{sdr_rd_vld_i & xfer_s & ~we_q}};
  assign port_rdata_o    = sdr_rdata_out_i;

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// Scoreboard bench for sdr_port_arbiter: directed transactions push expected
// request/done events; a negedge monitor pops and compares them.
module tb_sdr_port_arbiter;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int BL = 8;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0]    port_req    = 2'b00;
  logic [NP-1:0]    port_we     = 2'b01;
  logic [NP*AW-1:0] port_addr   = {32'h0000_0100, 32'h0000_0000};
  logic [NP*DW-1:0] port_wdata  = {16'hB1B1, 16'hA0A0};
  logic [NP-1:0]    port_wr_vld = 2'b11;
  logic [NP-1:0]    port_wr_ready, port_rd_vld, port_grant, port_done, port_err;
  logic [DW-1:0]    port_rdata, sdr_wdata_in;
  logic             sdr_wr_req, sdr_rd_req, sdr_wr_vld;
  logic [AW-1:0]    sdr_waddr, sdr_raddr;
  logic             sdr_wr_ready = 1'b1;
  logic [DW-1:0]    sdr_rdata = 16'h5A5A;
  logic             rd_en = 1'b0;
  logic             sdr_rd_vld;

  int tests = 0;
  int fails = 0;
  int bcnt  = 0;

  typedef struct {
    bit            is_done;
    bit            we;
    logic [AW-1:0] addr;
    logic [NP-1:0] grant;
    logic [DW-1:0] wdata;
    logic [NP-1:0] done;
    logic [NP-1:0] err;
    int            beats;
  } exp_t;
  exp_t exp_q[$];

  assign sdr_rd_vld = rd_en;

  sdr_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .port_req_i(port_req), .port_we_i(port_we), .port_addr_i(port_addr),
    .port_wdata_i(port_wdata), .port_wr_vld_i(port_wr_vld),
    .port_wr_ready_o(port_wr_ready), .port_rdata_o(port_rdata),
    .port_rd_vld_o(port_rd_vld), .port_grant_o(port_grant),
    .port_done_o(port_done), .port_err_o(port_err),
    .sdr_wr_req_o(sdr_wr_req), .sdr_rd_req_o(sdr_rd_req),
    .sdr_waddr_o(sdr_waddr), .sdr_raddr_o(sdr_raddr),
    .sdr_wdata_in_o(sdr_wdata_in), .sdr_wr_vld_o(sdr_wr_vld),
    .sdr_wr_ready_i(sdr_wr_ready), .sdr_rdata_out_i(sdr_rdata),
    .sdr_rd_vld_i(sdr_rd_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_txn(input int port, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input bit err, input int beats, input bit with_done);
    exp_t e;
    e.is_done = 1'b0; e.we = we; e.addr = addr; e.grant = NP'(1) << port;
    e.wdata = wd; e.done = '0; e.err = '0; e.beats = 0;
    exp_q.push_back(e);
    if (with_done) begin
      e.is_done = 1'b1;
      e.done    = NP'(1) << port;
      e.err     = err ? (NP'(1) << port) : '0;
      e.beats   = beats;
      exp_q.push_back(e);
    end
  endtask

  task automatic start(input logic [NP-1:0] r);
    @(negedge clk);
    port_req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input logic [NP-1:0] mask, input int max, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (((port_done & mask) == '0) && (cyc < max));
    if ((port_done & mask) == '0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, port_grant, 0);
    chk({tag, "_done"}, port_done, 0);
    chk({tag, "_err"}, port_err, 0);
    chk({tag, "_wr_req"}, sdr_wr_req, 0);
    chk({tag, "_rd_req"}, sdr_rd_req, 0);
    chk({tag, "_rd_vld"}, port_rd_vld, 0);
    chk({tag, "_wr_ready"}, port_wr_ready, 0);
    chk({tag, "_sdr_wr_vld"}, sdr_wr_vld, 0);
    chk({tag, "_waddr"}, sdr_waddr, 0);
    chk({tag, "_raddr"}, sdr_raddr, 0);
    chk({tag, "_wdata_in"}, sdr_wdata_in, 0);
  endtask

  // Monitor: counts granted-port beats and pops expectations on req/done pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        bcnt = 0;
      end else begin
        if (((port_wr_ready & port_wr_vld & port_grant) != '0) || (port_rd_vld != '0)) bcnt++;
        if (port_rd_vld != '0) chk("rd_vld_routing", port_rd_vld & ~port_grant, 0);
        if (sdr_wr_req || sdr_rd_req) begin
          if (exp_q.size() == 0) chk("unexpected_req", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("req_kind", e.is_done, 0);
            chk("sdr_wr_req", sdr_wr_req, e.we);
            chk("sdr_rd_req", sdr_rd_req, !e.we);
            chk("sdr_addr", e.we ? sdr_waddr : sdr_raddr, e.addr);
            chk("req_grant", port_grant, e.grant);
            chk("wdata_mux", sdr_wdata_in, e.wdata);
          end
          bcnt = 0;
        end
        if (port_done != '0) begin
          if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("done_kind", e.is_done, 1);
            chk("port_done", port_done, e.done);
            chk("port_err", port_err, e.err);
            chk("beat_count", bcnt, e.beats);
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Port0 write @0: request one cycle after req, done 9 cycles after grant
    push_txn(0, 1'b1, 32'h0, 16'hA0A0, 1'b0, BL, 1'b1);
    start(2'b01);
    chk("t1_grant_lat", port_grant, 2'b01);
    chk("t1_wr_req_lat", sdr_wr_req, 1);
    wait_done(2'b01, 40, cyc);
    chk("t1_done_lat", cyc, 9);
    port_req = 2'b00;
    idle(3);

    // Port1 read @0x100
    rd_en = 1'b1;
    push_txn(1, 1'b0, 32'h100, 16'hB1B1, 1'b0, BL, 1'b1);
    start(2'b10);
    chk("t2_rd_req", sdr_rd_req, 1);
    chk("t2_raddr", sdr_raddr, 32'h100);
    wait_done(2'b10, 40, cyc);
    port_req = 2'b00;
    rd_en = 1'b0;
    idle(3);

    // Both ports held: grants alternate 0,1,0,1 with an IDLE cycle between
    rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_txn(0, 1'b1, 32'h0, 16'hA0A0, 1'b0, BL, 1'b1);
      else            push_txn(1, 1'b0, 32'h100, 16'hB1B1, 1'b0, BL, 1'b1);
    end
    @(negedge clk);
    port_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done(2'b11, 40, cyc);
      chk("t3_spacing", cyc, (k == 0) ? 10 : 11);
    end
    port_req = 2'b00;
    rd_en = 1'b0;
    idle(3);

    // Write with controller never ready: watchdog after 20 XFER cycles
    sdr_wr_ready = 1'b0;
    push_txn(0, 1'b1, 32'h0, 16'hA0A0, 1'b1, 0, 1'b1);
    start(2'b01);
    chk("t4_grant", port_grant, 2'b01);
    wait_done(2'b01, 60, cyc);
    chk("t4_timeout_cycles", cyc, 21);
    chk("t4_err_with_done", port_err, 2'b01);
    port_req = 2'b00;
    sdr_wr_ready = 1'b1;
    idle(3);

    // Reset during 4th read beat, then both ports request: port 0 must win
    rd_en = 1'b1;
    push_txn(1, 1'b0, 32'h100, 16'hB1B1, 1'b0, 0, 1'b0);
    start(2'b10);
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (port_rd_vld[1]) n++;
    end
    chk("t5_beats_before_rst", n, 4);
    rst = 1'b1;
    port_req = 2'b00;
    #1;
    chk_all_zero("t5_midrst");
    rd_en = 1'b0;
    push_txn(0, 1'b1, 32'h0, 16'hA0A0, 1'b0, BL, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    port_req = 2'b11;
    @(posedge clk);
    #1;
    chk("t5_regrant", port_grant, 2'b01);
    wait_done(2'b01, 40, cyc);
    port_req = 2'b00;
    idle(3);

    // Port0 drops request right after grant; burst still completes
    push_txn(0, 1'b1, 32'h0, 16'hA0A0, 1'b0, BL, 1'b1);
    start(2'b01);
    port_req = 2'b00;
    chk("t6_grant", port_grant, 2'b01);
    wait_done(2'b01, 40, cyc);
    chk("t6_done_lat", cyc, 9);
    idle(3);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
